// File: rtl/burst_mem_if.sv
// Burst memory bus between the cache line adaptor and the physical-memory responder.
// Carries the held line request (read/write, address, byte enables), the 64-bit write
// beat and the registered read beat / beat strobe returned by the responder.
//   master : adaptor side, drives the request and the write beats
//   slave  : responder side, drives mem_rdata and mem_resp
interface burst_mem_if;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_byte_enable;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_resp;

  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/burst_mem_responder.sv
// Physical-memory-side responder for the 64-bit line burst bus.
// Captures a held read/write request for one 256-bit line, waits LATENCY cycles, then
// moves the line as four contiguous 64-bit beats strobed by mem_resp. The line is backed
// by an internal array of 4*DEPTH_LINES words that reset does not clear.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : burst_mem_if slave (request in, mem_rdata/mem_resp out, both registered)
// Parameters:
//   DEPTH_LINES : lines stored, power of two, >= 2
//   LATENCY     : wait cycles between capture and first beat, >= 1
module burst_mem_responder #(
  parameter int unsigned DEPTH_LINES = 256,
  parameter int unsigned LATENCY     = 4
) (
  input  logic       clk,
  input  logic       rst,
  burst_mem_if.slave bus
);

  localparam int unsigned BEATS  = 4;
  localparam int unsigned LINE_W = $clog2(DEPTH_LINES);
  localparam int unsigned WORD_W = LINE_W + 2;
  localparam int unsigned WORDS  = BEATS * DEPTH_LINES;
  localparam int unsigned WAIT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  // Elaboration-time parameter sanity checks
  if (DEPTH_LINES < 2 || (DEPTH_LINES & (DEPTH_LINES - 1)) != 0) begin : g_bad_depth
    $error("DEPTH_LINES must be a power of two >= 2");
  end
  if (LATENCY < 1) begin : g_bad_latency
    $error("LATENCY must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Line storage, word index = {line, beat}
  logic [63:0] mem [WORDS];

  state_t              state, state_next;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_next;
  logic [1:0]          beat, beat_next;
  logic [LINE_W-1:0]   line, line_next;
  logic                op_read, op_read_next;
  logic                resp, resp_next;
  logic [63:0]         rdata, rdata_next;

  logic                we_c;
  logic [WORD_W-1:0]   rd_idx_c;
  logic [WORD_W-1:0]   wr_idx_c;

  // Only the line-index bits of the address are meaningful
  logic unused_addr_c;
  assign unused_addr_c = ^bus.mem_address;

  assign bus.mem_resp  = resp;
  assign bus.mem_rdata = rdata;

  // State register, including the registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      beat     <= '0;
      line     <= '0;
      op_read  <= 1'b0;
      resp     <= 1'b0;
      rdata    <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      beat     <= beat_next;
      line     <= line_next;
      op_read  <= op_read_next;
      resp     <= resp_next;
      rdata    <= rdata_next;
    end
  end

  // Next-state logic; op and line are latched once in IDLE and held for the whole burst
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    beat_next     = beat;
    line_next     = line;
    op_read_next  = op_read;
    unique case (state)
      S_IDLE: begin
        if (bus.mem_read || bus.mem_write) begin
          line_next     = bus.mem_address[5 +: LINE_W];
          op_read_next  = bus.mem_read;  // read wins when both are asserted
          wait_cnt_next = WAIT_W'(LATENCY - 1);
          state_next    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt == '0) begin
          beat_next  = 2'd0;
          state_next = S_BURST;
        end else begin
          wait_cnt_next = wait_cnt - WAIT_W'(1);
        end
      end
      S_BURST: begin
        if (beat == 2'd3) begin
          state_next = S_DONE;
        end else begin
          beat_next = beat + 2'd1;
        end
      end
      S_DONE: begin
        // Request inputs ignored here so a still-held request cannot re-trigger
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic: values for the registered strobe/data of the following cycle.
  // The read beat for cycle n+1 is fetched while cycle n is in progress.
  always_comb begin
    resp_next  = 1'b0;
    rdata_next = '0;
    we_c       = 1'b0;
    rd_idx_c   = {line, 2'd0};
    wr_idx_c   = {line, beat};
    unique case (state)
      S_WAIT: begin
        if (wait_cnt == '0) begin
          resp_next = 1'b1;
          rd_idx_c  = {line, 2'd0};
          if (op_read) rdata_next = mem[rd_idx_c];
        end
      end
      S_BURST: begin
        we_c = !op_read;
        if (beat != 2'd3) begin
          resp_next = 1'b1;
          rd_idx_c  = {line, beat + 2'd1};
          if (op_read) rdata_next = mem[rd_idx_c];
        end
      end
      default: begin
        resp_next  = 1'b0;
        rdata_next = '0;
      end
    endcase
  end

  // Byte-masked write of the current beat; a reset edge suppresses the write
  always_ff @(posedge clk) begin
    if (we_c && !rst) begin
      for (int b = 0; b < 8; b++) begin
        if (bus.mem_byte_enable[{beat, 3'(b)}]) begin
          mem[wr_idx_c][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_burst_mem_responder.sv
// Scoreboard bench for burst_mem_responder: the stimulus tasks push the expected beat
// (data and cycle of arrival) into a queue, a negedge monitor pops and checks every beat.
module tb_burst_mem_responder;

  localparam int unsigned LATENCY = 4;
  localparam int unsigned DEPTH   = 256;

  typedef logic [3:0][63:0] line_t;
  typedef struct {
    logic [63:0] data;
    int          cyc;
    bit          chk;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  burst_mem_if bus();

  burst_mem_responder #(.DEPTH_LINES(DEPTH), .LATENCY(LATENCY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic line_t mk(input logic [63:0] b0, b1, b2, b3);
    line_t l;
    l[0] = b0; l[1] = b1; l[2] = b2; l[3] = b3;
    return l;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every mem_resp cycle must match the head of the scoreboard
  always @(negedge clk) begin
    if (bus.mem_resp === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_resp: got resp at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("beat_cycle", 64'(cyc), 64'(e.cyc));
        if (e.chk) check("beat_data", bus.mem_rdata, e.data);
      end
    end
  end

  // One transaction; returns in the first IDLE cycle after DONE
  task automatic txn(input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [31:0] addr_alt, input logic [31:0] be,
                     input line_t wd, input line_t ex, input bit chk, input bit keep);
    int t;
    exp_t e;
    bus.mem_address     = addr;
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.mem_byte_enable = be;
    bus.mem_wdata       = '0;
    for (int k = 0; k < 4; k++) begin
      e.data = rd ? ex[k] : 64'd0;
      e.cyc  = cyc + int'(LATENCY) + 1 + k;
      e.chk  = chk;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    bus.mem_address = addr_alt;
    t = 0;
    while (bus.mem_resp !== 1'b1 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (bus.mem_resp !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL resp_timeout: got no resp after %0d cycles expected resp", t);
    end
    for (int k = 0; k < 4; k++) begin
      bus.mem_wdata = wd[k];
      @(posedge clk); #1;
    end
    if (!keep) begin
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  line_t zero4, ones4, l1234, l3, l4, junk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    zero4 = mk(64'd0, 64'd0, 64'd0, 64'd0);
    ones4 = mk({64{1'b1}}, {64{1'b1}}, {64{1'b1}}, {64{1'b1}});
    l1234 = mk(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
               64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
    l3    = mk(64'h3030_0000_0000_0001, 64'h3030_0000_0000_0002,
               64'h3030_0000_0000_0003, 64'h3030_0000_0000_0004);
    l4    = mk(64'h4040_0000_0000_0001, 64'h4040_0000_0000_0002,
               64'h4040_0000_0000_0003, 64'h4040_0000_0000_0004);
    junk  = mk(64'hDEAD_BEEF_DEAD_BEEF, 64'hDEAD_BEEF_DEAD_BEEF,
               64'hDEAD_BEEF_DEAD_BEEF, 64'hDEAD_BEEF_DEAD_BEEF);

    // Reset held 2 cycles with a read pending: outputs stay quiet
    rst                 = 1'b1;
    bus.mem_address     = 32'h0;
    bus.mem_read        = 1'b1;
    bus.mem_write       = 1'b0;
    bus.mem_byte_enable = '0;
    bus.mem_wdata       = '0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("rst_resp", 64'(bus.mem_resp), 64'd0);
      check("rst_rdata", bus.mem_rdata, 64'd0);
    end
    rst = 1'b0;
    // Held read accepted after release, first beat LATENCY+1 later; data undefined
    txn(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, zero4, zero4, 1'b0, 1'b0);

    // Write then read line 2
    txn(1'b0, 1'b1, 32'h40, 32'h40, 32'hFFFF_FFFF, l1234, zero4, 1'b1, 1'b0);
    txn(1'b1, 1'b0, 32'h40, 32'h40, 32'h0, zero4, l1234, 1'b1, 1'b0);

    // Partial write over an all-ones line
    txn(1'b0, 1'b1, 32'h40, 32'h40, 32'hFFFF_FFFF, ones4, zero4, 1'b1, 1'b0);
    txn(1'b0, 1'b1, 32'h40, 32'h40, 32'h0000_00F0,
        mk(64'h0123_4567_89AB_CDEF, 64'd0, 64'd0, 64'd0), zero4, 1'b1, 1'b0);
    txn(1'b1, 1'b0, 32'h40, 32'h40, 32'h0, zero4,
        mk(64'h0123_4567_FFFF_FFFF, {64{1'b1}}, {64{1'b1}}, {64{1'b1}}), 1'b1, 1'b0);

    // Held read through DONE: second transaction starts on the first IDLE cycle
    txn(1'b1, 1'b0, 32'h40, 32'h40, 32'h0, zero4, l1234 & 0 | ones4, 1'b0, 1'b1);
    txn(1'b1, 1'b0, 32'h40, 32'h40, 32'h0, zero4,
        mk(64'h0123_4567_FFFF_FFFF, {64{1'b1}}, {64{1'b1}}, {64{1'b1}}), 1'b1, 1'b0);
    // Request dropped in DONE: any further beat is flagged by the monitor
    repeat (12) @(posedge clk);
    #1;

    // Read/write collision at 0x60 with the address moved to 0x80 during WAIT
    txn(1'b0, 1'b1, 32'h60, 32'h60, 32'hFFFF_FFFF, l3, zero4, 1'b1, 1'b0);
    txn(1'b0, 1'b1, 32'h80, 32'h80, 32'hFFFF_FFFF, l4, zero4, 1'b1, 1'b0);
    txn(1'b1, 1'b1, 32'h60, 32'h80, 32'hFFFF_FFFF, junk, l3, 1'b1, 1'b0);
    txn(1'b1, 1'b0, 32'h80, 32'h80, 32'h0, zero4, l4, 1'b1, 1'b0);
    txn(1'b1, 1'b0, 32'h60, 32'h60, 32'h0, zero4, l3, 1'b1, 1'b0);

    // Mid-burst reset during beat 2 of a write to line 5 (cleared first)
    txn(1'b0, 1'b1, 32'hA0, 32'hA0, 32'hFFFF_FFFF, zero4, zero4, 1'b1, 1'b0);
    begin
      exp_t e;
      int t;
      bus.mem_address     = 32'hA0;
      bus.mem_read        = 1'b0;
      bus.mem_write       = 1'b1;
      bus.mem_byte_enable = 32'hFFFF_FFFF;
      for (int k = 0; k < 3; k++) begin
        e.data = 64'd0;
        e.cyc  = cyc + int'(LATENCY) + 1 + k;
        e.chk  = 1'b1;
        sb.push_back(e);
      end
      t = 0;
      @(posedge clk); #1;
      while (bus.mem_resp !== 1'b1 && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      check("midrst_resp_seen", 64'(bus.mem_resp), 64'd1);
      bus.mem_wdata = 64'hAAAA_AAAA_AAAA_AAAA;
      @(posedge clk); #1;
      bus.mem_wdata = 64'hBBBB_BBBB_BBBB_BBBB;
      @(posedge clk); #1;
      bus.mem_wdata = 64'hCCCC_CCCC_CCCC_CCCC;
      rst           = 1'b1;
      bus.mem_write = 1'b0;
      @(posedge clk); #1;
      check("midrst_resp", 64'(bus.mem_resp), 64'd0);
      check("midrst_rdata", bus.mem_rdata, 64'd0);
      rst = 1'b0;
      bus.mem_wdata = 64'hDDDD_DDDD_DDDD_DDDD;
      @(posedge clk); #1;
    end
    txn(1'b1, 1'b0, 32'hA0, 32'hA0, 32'h0, zero4,
        mk(64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB, 64'd0, 64'd0), 1'b1, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/burst_mem_responder.md
# burst_mem_responder

Physical-memory-side responder for the 64-bit burst interface driven by the cache line adaptor. It accepts a held read or write request for one 256-bit line, waits a programmable access latency, then moves the line as four 64-bit beats, each qualified by `mem_resp`. It backs the line with an internal word array and serves as the pmem endpoint in simulation and FPGA bring-up. The adaptor's serializer supplies the write beats, and its deserializer collects the read beats.

## Interface
- `DEPTH_LINES`, default 256: number of 32-byte lines stored; must be a power of two, at least 2.
- `LATENCY`, default 4: number of wait cycles between request capture and the first beat; must be at least 1.
- `clk`, in, 1: the single clock. All state changes on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `mem_address`, in, 32: byte address. Bits [4:0] are ignored. The line index is `mem_address[5 +: log2(DEPTH_LINES)]`.
- `mem_read`, in, 1: read-line request, held high until the burst completes.
- `mem_write`, in, 1: write-line request, held high until the burst completes.
- `mem_byte_enable`, in, 32: per-byte write enables for the whole line. Beat k uses bits [8k+7:8k], with bit 0 of each slice enabling byte 0 of the beat.
- `mem_wdata`, in, 64: write beat, sampled on each edge where `mem_resp`=1.
- `mem_rdata`, out, 64: read beat, valid while `mem_resp`=1. Registered.
- `mem_resp`, out, 1: beat strobe. Registered.

## Operation
- Storage is an array of `4*DEPTH_LINES` 64-bit words. Word index is `{line, beat[1:0]}`.
- The array is not cleared by reset. Its initial contents are undefined unless loaded by the bench.
- **FSM states:** IDLE, WAIT, BURST, DONE.
- **IDLE:**
  - If `mem_read` or `mem_write` is high, latch the line index and the op, load `wait_cnt`=LATENCY-1, then go to WAIT.
  - If both are high, the op is READ.
- **WAIT:**
  - If `wait_cnt`=0, set `beat`=0 and go to BURST. Otherwise decrement `wait_cnt`.
  - `mem_resp` and `mem_rdata` are driven for beat 0 at the WAIT→BURST edge.
- **BURST:** four cycles, `beat` = 0..3, with `mem_resp`=1 in every one.
  - READ: `mem_rdata` = `mem[{line,beat}]`.
  - WRITE: on each edge, every enabled byte of `mem_wdata` is written into `mem[{line,beat}]`. `mem_rdata` holds 0.
  - After beat 3, go to DONE.
- **DONE:**
  - Hold for one cycle with `mem_resp`=0, ignoring the request inputs so that a request still held cannot re-trigger. Then go to IDLE.
  - The requester must drop its request no later than the DONE cycle.
- Request inputs and address changes during WAIT or BURST are ignored; the latched op and line are used.
- A read that follows a write to the same line returns the newly written bytes. Disabled bytes keep their old value.

## Timing
- **Reset values:** state IDLE, `mem_resp`=0, `mem_rdata`=0, `wait_cnt`=0, `beat`=0.
- **Reset mid-burst:** at the next edge the FSM returns to IDLE and `mem_resp`=0.
  - Beats already written stay written. No further beats are written.
  - A request still held after reset is accepted as a new transaction.
- **Latency:** with the request first high in IDLE at cycle 0, `mem_resp`=1 in cycles LATENCY+1 through LATENCY+4.
  - Cycle LATENCY+5 is DONE.
  - The earliest next capture is cycle LATENCY+6.
- Back-to-back transactions therefore cost LATENCY+6 cycles each.
- `mem_resp` pulses are exactly four and contiguous; there are no gaps and no backpressure.
- Write beat k is sampled on the edge ending the k-th `mem_resp` cycle.
- Read beat k is presented during the k-th `mem_resp` cycle.

## Test plan
- **Reset:** hold `rst` for 2 cycles with `mem_read`=1 → `mem_resp`=0 and `mem_rdata`=0 throughout. The first `mem_resp` occurs LATENCY+1 cycles after release (cycle 5 with LATENCY=4).
- **Write then read:**
  - Write line at 0x0000_0040 with all bytes enabled, beats 0x1111_1111_1111_1111, 0x2222…, 0x3333…, 0x4444….
  - Then read the same address → 4 contiguous `mem_resp` cycles returning 0x1111…, 0x2222…, 0x3333…, 0x4444… in order, at cycles 5–8 relative to the read request.
- **Partial write:**
  - Preload line 2 with all 0xFF. Write with `mem_byte_enable`=0x0000_00F0 and beat 0 = 0x0123_4567_89AB_CDEF.
  - Read back → beat 0 = 0x0123_4567_FFFF_FFFF; beats 1–3 = 0xFFFF_FFFF_FFFF_FFFF.
- **Held request / DONE:**
  - Keep `mem_read` high through DONE and the cycle after → exactly 4 `mem_resp` pulses, then a second transaction starts on the first IDLE cycle.
  - Drop the request in DONE → no second transaction.
- **Read/write collision and address change:**
  - Assert `mem_read`=`mem_write`=1 at 0x60 → read of line 3.
  - Change `mem_address` to 0x80 during WAIT → line 3 is still returned and line 4 is unchanged.
- **Mid-burst reset:**
  - Assert `rst` during beat 2 of a write to line 5 with beats 0xA…, 0xB…, 0xC…, 0xD…, over old contents 0.
  - Reread → beats 0 and 1 updated to 0xA… and 0xB…; beats 2 and 3 remain 0; `mem_resp`=0 on the edge after reset.
